fp_add_share_ctrl: RTL and testbench

Shares one single-cycle FP adder (`fp_add_single_cycle`, registered output, 1-cycle latency) between NUM_REQ independent requesters. Requests use valid/ready handshakes and are granted round-robin, with at most one issue per cycle. Each requester gets a registered result buffer with its own valid/ready handshake. The block sits between the vector/softmax engines and the shared FP8 adder.

---
 rtl/fp_pkg.sv | 14 +
 rtl/fp_add_single_cycle.sv | 83 ++++++++
 rtl/fp_rr_arbiter.sv | 32 +++
 rtl/fp_add_share_ctrl.sv | 101 ++++++++++
 tb/tb_fp_add_share_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_pkg : FP8 format defaults and constants shared by the FP blocks  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package fp_pkg;
  localparam int FP_EXP_WIDTH      = 4;
  localparam int FP_MANTISSA_WIDTH = 3;
  localparam int FP_FPW            = FP_EXP_WIDTH + FP_MANTISSA_WIDTH + 1;

  localparam logic [7:0] FP_ONE  = 8'h38;
  localparam logic [7:0] FP_ZERO = 8'h00;
endpackage
`default_nettype wire

// File: rtl/fp_add_single_cycle.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_add_single_cycle : FP adder, registered output, 1-cycle latency  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fp_add_single_cycle import fp_pkg::*; #(
  parameter int  EXP_WIDTH      = FP_EXP_WIDTH,
  parameter int  MANTISSA_WIDTH = FP_MANTISSA_WIDTH,
  localparam int FPW            = EXP_WIDTH + MANTISSA_WIDTH + 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_vld,
  input  logic [FPW-1:0] a,
  input  logic [FPW-1:0] b,
  output logic           out_vld,
  output logic [FPW-1:0] sum
);
  localparam int GW = MANTISSA_WIDTH + 4;
  localparam int EW = EXP_WIDTH + 2;
  localparam logic signed [EW-1:0] c_one  = EW'(1);
  localparam logic signed [EW-1:0] c_zero = '0;
  localparam logic signed [EW-1:0] c_emax = EW'((1 << EXP_WIDTH) - 1);

  logic [FPW-1:0]        w_big, w_small, w_sum;
  logic [EXP_WIDTH-1:0]  w_dexp;
  logic [GW-1:0]         w_m_big, w_m_small;
  logic [GW:0]           w_m;
  logic signed [EW-1:0]  w_e;
  logic                  r_vld;
  logic [FPW-1:0]        r_sum;

  // Zero exponent is treated as zero (no subnormals); extra bits are truncated.
  always_comb begin
    w_big   = a;
    w_small = b;
    if (b[FPW-2:0] > a[FPW-2:0]) begin
      w_big   = b;
      w_small = a;
    end
    w_m_big   = (w_big[FPW-2 -: EXP_WIDTH] == '0) ? '0 :
                {1'b1, w_big[MANTISSA_WIDTH-1:0], 3'b000};
    w_m_small = (w_small[FPW-2 -: EXP_WIDTH] == '0) ? '0 :
                {1'b1, w_small[MANTISSA_WIDTH-1:0], 3'b000};
    w_dexp    = w_big[FPW-2 -: EXP_WIDTH] - w_small[FPW-2 -: EXP_WIDTH];
    w_m_small = w_m_small >> w_dexp;
    if (w_big[FPW-1] == w_small[FPW-1])
      w_m = {1'b0, w_m_big} + {1'b0, w_m_small};
    else
      w_m = {1'b0, w_m_big} - {1'b0, w_m_small};
    w_e = {2'b00, w_big[FPW-2 -: EXP_WIDTH]};
    if (w_m[GW]) begin
      w_m = w_m >> 1;
      w_e = w_e + c_one;
    end
    for (int k = 0; k < GW; k++) begin
      if (w_m != '0 && !w_m[GW-1]) begin
        w_m = w_m << 1;
        w_e = w_e - c_one;
      end
    end
    if (w_m == '0 || w_e <= c_zero)
      w_sum = '0;
    else if (w_e > c_emax)
      w_sum = {w_big[FPW-1], {(FPW-1){1'b1}}};
    else
      w_sum = {w_big[FPW-1], w_e[EXP_WIDTH-1:0], w_m[GW-2 -: MANTISSA_WIDTH]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld <= 1'b0;
      r_sum <= '0;
    end else begin
      r_vld <= in_vld;
      r_sum <= w_sum;
    end
  end

  assign out_vld = r_vld;
  assign sum     = r_sum;
endmodule
`default_nettype wire

// File: rtl/fp_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_rr_arbiter : combinational round-robin pick starting at ptr      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fp_rr_arbiter import fp_pkg::*; #(
  parameter int  N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [IW-1:0] w_idx;

  // Scan from the farthest offset back to ptr so the nearest eligible wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = IW'((int'(ptr) + k) % N);
      if (eligible[w_idx]) begin
        grant        = '0;
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/fp_add_share_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_add_share_ctrl : round-robin sharing of one FP adder, per-       |
// | requester result buffers.                       Rev 1.0             |
// +--------------------------------------------------------------------+
module fp_add_share_ctrl import fp_pkg::*; #(
  parameter int  EXP_WIDTH      = FP_EXP_WIDTH,
  parameter int  MANTISSA_WIDTH = FP_MANTISSA_WIDTH,
  parameter int  NUM_REQ        = 4,
  localparam int FPW            = EXP_WIDTH + MANTISSA_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*FPW-1:0] req_a,
  input  logic [NUM_REQ*FPW-1:0] req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [NUM_REQ*FPW-1:0] rsp_data,
  output logic                   busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] c_last = IW'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]     w_eligible, w_grant, w_rsp_hs, r_pending, r_rsp_valid;
  logic [IW-1:0]          w_grant_idx, r_ptr, r_iss_id, r_add_id;
  logic [FPW-1:0]         w_op_a, w_op_b, r_iss_a, r_iss_b, w_add_sum;
  logic                   r_iss_vld, w_add_vld;
  logic [NUM_REQ*FPW-1:0] r_rsp_data;

  // A requester with a result outstanding is masked until its buffer drains.
  assign w_eligible = req_valid & ~r_pending;
  assign w_rsp_hs   = r_rsp_valid & rsp_ready;

  fp_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .eligible  (w_eligible),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    if (|w_grant) begin
      w_op_a = req_a[w_grant_idx*FPW +: FPW];
      w_op_b = req_b[w_grant_idx*FPW +: FPW];
    end
  end

  fp_add_single_cycle #(
    .EXP_WIDTH      (EXP_WIDTH),
    .MANTISSA_WIDTH (MANTISSA_WIDTH)
  ) u_add (
    .clk     (clk),
    .rstn    (rstn),
    .in_vld  (r_iss_vld),
    .a       (r_iss_a),
    .b       (r_iss_b),
    .out_vld (w_add_vld),
    .sum     (w_add_sum)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr       <= '0;
      r_pending   <= '0;
      r_iss_vld   <= 1'b0;
      r_iss_id    <= '0;
      r_iss_a     <= '0;
      r_iss_b     <= '0;
      r_add_id    <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (|w_grant)
        r_ptr <= (w_grant_idx == c_last) ? '0 : w_grant_idx + 1'b1;
      r_pending <= (r_pending | w_grant) & ~w_rsp_hs;
      r_iss_vld <= |w_grant;
      r_iss_id  <= w_grant_idx;
      r_iss_a   <= w_op_a;
      r_iss_b   <= w_op_b;
      r_add_id  <= r_iss_id;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_add_vld && r_add_id == IW'(i)) begin
          r_rsp_valid[i]             <= 1'b1;
          r_rsp_data[i*FPW +: FPW]   <= w_add_sum;
        end else if (w_rsp_hs[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_iss_vld | w_add_vld | (|r_rsp_valid);
endmodule
`default_nettype wire

// File: tb/tb_fp_add_share_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fp_add_share_ctrl : directed + random bench with transaction     |
// | reference model.                                Rev 1.0             |
// +--------------------------------------------------------------------+
module tb_fp_add_share_ctrl;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    int         id;
    int         due;
    logic [7:0] val;
  } fly_t;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '0;
  logic [N*W-1:0] rsp_data;
  logic           busy;

  fly_t       m_fly[$];
  bit         m_pend[N];
  bit         m_full[N];
  logic [7:0] m_data[N];
  int         m_ptr;
  int         m_edge;
  int         n_checks = 0;
  int         n_errors = 0;
  real        ra[N];
  real        rb[N];
  logic [N-1:0] v  = '0;
  logic [N-1:0] rr = '0;
  real        vals[8] = '{0.5, 1.0, 1.5, 2.0, 3.0, -1.0, -0.5, -2.0};

  fp_add_share_ctrl #(.EXP_WIDTH(4), .MANTISSA_WIDTH(3), .NUM_REQ(N)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Exact real -> FP8 (E4M3, bias 7); only used on exactly representable values.
  function automatic logic [7:0] enc(input real x);
    real  m;
    int   e;
    logic s;
    if (x == 0.0) return 8'h00;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    return {s, 4'(e + 7), 3'($rtoi((m - 1.0) * 8.0))};
  endfunction

  task automatic model_clear();
    m_fly.delete();
    m_ptr  = 0;
    m_edge = 0;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_full[i] = 0;
      m_data[i] = 8'h00;
    end
  endtask

  // One clock cycle: drive at negedge, check outputs, then advance the model past the posedge.
  task automatic cycle();
    int           g;
    int           idx;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_vld;
    logic         exp_busy;
    @(negedge clk);
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = enc(ra[i]);
      req_b[i*W +: W] = enc(rb[i]);
    end
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && v[idx] && !m_pend[idx]) g = idx;
    end
    exp_rdy  = (g >= 0) ? N'(1 << g) : '0;
    exp_busy = (m_fly.size() != 0);
    for (int i = 0; i < N; i++) begin
      exp_vld[i] = m_full[i];
      if (m_full[i]) exp_busy = 1'b1;
    end
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    for (int i = 0; i < N; i++)
      check_eq($sformatf("rsp_data%0d", i), 32'(rsp_data[i*W +: W]), 32'(m_data[i]));
    m_edge++;
    for (int i = 0; i < N; i++) begin
      if (m_full[i] && rr[i]) begin
        m_full[i] = 0;
        m_pend[i] = 0;
      end
    end
    for (int j = m_fly.size() - 1; j >= 0; j--) begin
      if (m_fly[j].due == m_edge) begin
        m_full[m_fly[j].id] = 1;
        m_data[m_fly[j].id] = m_fly[j].val;
        m_fly.delete(j);
      end
    end
    if (g >= 0) begin
      m_pend[g] = 1;
      m_fly.push_back('{id: g, due: m_edge + 2, val: enc(ra[g] + rb[g])});
      m_ptr = (g + 1) % N;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    v = '0;
    rr = '0;
    req_valid = '0;
    rsp_ready = '0;
    rstn = 1'b0;
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'h0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rsp_data", rsp_data, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic drain();
    v  = '0;
    rr = '1;
    repeat (5) cycle();
    rr = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin ra[i] = 0.0; rb[i] = 0.0; end
    model_clear();
    do_reset();

    // Single request: 1.0 + 1.0
    ra[0] = 1.0; rb[0] = 1.0; v = 4'b0001;
    cycle();
    check_eq("t1_grant", 32'(req_ready), 32'h1);
    v = '0;
    repeat (3) cycle();
    check_eq("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("t1_data", 32'(rsp_data[7:0]), 32'h40);
    rr = 4'b0001;
    cycle();
    rr = '0;
    cycle();
    check_eq("t1_busy_after", 32'(busy), 32'h0);

    // All requesters, round-robin from ptr 0, 1.5 + 1.5
    do_reset();
    for (int i = 0; i < N; i++) begin ra[i] = 1.5; rb[i] = 1.5; end
    v = '1; rr = '1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check_eq("t2_grant_order", 32'(req_ready), 32'(1 << (k % N)));
      for (int i = 0; i < N; i++)
        if (rsp_valid[i]) check_eq("t2_data", 32'(rsp_data[i*W +: W]), 32'h44);
    end
    drain();

    // Backpressure on requester 2: 2.0 + 1.0 held for 5 cycles
    ra[2] = 2.0; rb[2] = 1.0; v = 4'b0100; rr = '0;
    cycle();
    check_eq("t3_grant", 32'(req_ready), 32'h4);
    for (int k = 1; k <= 7; k++) begin
      cycle();
      check_eq("t3_no_regrant", 32'(req_ready[2]), 32'h0);
      if (k >= 3) begin
        check_eq("t3_held_valid", 32'(rsp_valid[2]), 32'h1);
        check_eq("t3_held_data", 32'(rsp_data[23:16]), 32'h44);
      end
    end
    rr = 4'b0100;
    cycle();
    rr = '0;
    cycle();
    check_eq("t3_regrant", 32'(req_ready), 32'h4);
    drain();

    // Cancellation on 1, requester 3 issuing the following cycle
    ra[1] = 1.0; rb[1] = -1.0; v = 4'b0010;
    cycle();
    check_eq("t4_grant1", 32'(req_ready), 32'h2);
    ra[3] = 1.5; rb[3] = 1.0; v = 4'b1000;
    cycle();
    check_eq("t4_grant3", 32'(req_ready), 32'h8);
    v = '0;
    repeat (3) cycle();
    check_eq("t4_rsp_valid", 32'(rsp_valid), 32'ha);
    check_eq("t4_data1", 32'(rsp_data[15:8]), 32'h00);
    check_eq("t4_data3", 32'(rsp_data[31:24]), 32'h42);
    drain();

    // Reset one cycle after an accept
    ra[2] = 3.0; rb[2] = 0.5; v = 4'b0100;
    cycle();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_eq("t5_no_stale_rsp", 32'(rsp_valid), 32'h0);
      check_eq("t5_idle", 32'(busy), 32'h0);
    end
    v = 4'b0110;
    cycle();
    check_eq("t5_first_grant", 32'(req_ready), 32'h2);
    drain();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        ra[i] = vals[$urandom_range(0, 7)];
        rb[i] = vals[$urandom_range(0, 7)];
      end
      v  = N'($urandom_range(0, (1 << N) - 1));
      rr = N'($urandom_range(0, (1 << N) - 1));
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
